dvp_capture: RTL and testbench
==============================

# dvp_capture

Parametrised DVP (OV5640-class) capture front end. It sits between the camera's pclk/href/vsync/data pins and the write-FIFO / frame-buffer writer. It packs N input beats into one pixel word and discards a programmable number of start-up frames, counted as true vsync edges rather than clocks. It also adds frame decimation, frame-atomic enable, pixel coordinates, SOF/EOL markers and fragment-error detection.

## Interface
- DATA_W, 8: input bus width per pclk beat.
- BEATS_PER_PIX, 2: beats packed per pixel, 1..4.
- PIC_WAIT, 10: vsync rising edges discarded after reset before any capture, 0..255.
- X_W, 12: pixel-column counter width.
- Y_W, 12: line counter width.
- ov5640_pclk  in  1  sole clock; all inputs sampled on its rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- ov5640_href  in  1  line valid.
- ov5640_vsync  in  1  frame sync; rising edge marks a frame boundary.
- ov5640_data  in  DATA_W  beat data.
- cap_en  in  1  capture enable; sampled only at a vsync rising edge.
- lsb_first  in  1  0: first beat lands in the MS slot; 1: first beat lands in the LS slot. Sampled at a vsync rising edge.
- skip  in  4  keep 1 frame of every skip+1. Sampled at a vsync rising edge.
- pix_valid  out  1  one-cycle strobe; the pixel outputs below are valid.
- pix_data  out  DATA_W\*BEATS_PER_PIX  packed pixel.
- pix_x  out  X_W  column of the pixel, 0-based.
- pix_y  out  Y_W  line of the pixel within the frame, 0-based.
- sof  out  1  qualifies the first pixel of a captured frame.
- eol  out  1  qualifies the last pixel of a line.
- frag_err  out  1  one-cycle pulse: href fell mid-pixel.
- err_cnt  out  8  saturating fragment-error count.
- frame_active  out  1  the current frame is being captured.

## Operation
- Frame FSM. It advances only on a vsync rising edge (vs_rise = vsync & ~vsync_q).
  - WAIT: count vs_rise events. At the vs_rise on which the count reaches PIC_WAIT, evaluate the acceptance rule. If PIC_WAIT=0, leave WAIT at the first vs_rise.
  - Acceptance rule at each vs_rise outside WAIT:
    - cap_en=0 → IDLE.
    - cap_en=1 → latch skip and lsb_first, then go to ACTIVE if the decimation counter is 0, otherwise SKIP.
    - The decimation counter increments mod (skip+1) on every vs_rise taken outside WAIT. It resets to 0 on any cap_en 0→1 observed at a vs_rise.
- frame_active = (state == ACTIVE).
- Packing is active only in ACTIVE with href=1.
  - A beat counter b advances 0..BEATS_PER_PIX-1 and wraps.
  - Each beat goes into slot b. With lsb_first=0, slot b maps to bits [(BEATS_PER_PIX-1-b)\*DATA_W +: DATA_W]; with lsb_first=1, to bits [b\*DATA_W +: DATA_W].
  - When the last beat is written, the pixel is complete and the next output stage fires.
- Fragment error: href falls while b≠0 in ACTIVE.
  - The partial pixel is dropped and b is cleared.
  - frag_err pulses and err_cnt increments, saturating at 255.
  - pix_x is unaffected.
- Coordinates:
  - pix_x clears on each href rising edge and increments after every emitted pixel. It saturates at all-ones.
  - pix_y clears at vs_rise. It increments at each href falling edge in ACTIVE that followed at least one emitted pixel.
- sof is 1 on the first pix_valid after entry to ACTIVE.
- eol = ~href sampled at the output-stage edge.
- Mid-frame changes: cap_en, skip and lsb_first are ignored between vs_rise events.
  - A frame in progress always completes.
  - A vs_rise in the middle of a line aborts packing: b clears and no frag_err is raised.

## Timing
- Reset values:
  - state=WAIT; all counters 0.
  - pix_valid, sof, eol, frag_err and frame_active are 0.
  - pix_data, pix_x, pix_y and err_cnt are 0.
- Latency: last beat sampled at edge k → pix_valid, pix_data, pix_x, pix_y, sof and eol are registered at edge k+1 and held high/valid for exactly one cycle.
- Back-to-back pixels:
  - BEATS_PER_PIX=1 allows pix_valid on consecutive cycles.
  - Otherwise pix_valid has a period of BEATS_PER_PIX cycles.
- frag_err is registered at the edge after the one that samples href=0.
- frame_active changes at the edge after the vs_rise sample.
- There is no backpressure. The downstream block must accept pix_valid every cycle.
- An asynchronous sys_rst mid-frame returns to WAIT. The PIC_WAIT discard then restarts from 0.

## Structure
- Shared package dvp_pkg holds:
  - the frame-state enum (WAIT, IDLE, ACTIVE, SKIP);
  - the err_cnt width constant;
  - the slot-index function shared by both byte orders.
- One sub-module is natural: dvp_pix_pack. It contains the beat counter, slot mapping, fragment detection and output register.
- The top level keeps the frame FSM, decimation and coordinate counters.

## Test plan
- Start-up discard: PIC_WAIT=3, 2 beats/pix, 4 frames of 4×2 pixels, beats 0x12,0x34,… → no pix_valid in frames 1–3. Frame 4 emits 8 pixels, the first being 0x1234 with sof=1, x=0, y=0.
- Byte order: lsb_first=1 at vs_rise, beats 0xAB,0xCD → pix_data=0xCDAB. Toggling lsb_first mid-frame has no effect until the next vs_rise.
- Decimation: skip=2, 6 accepted frames → pixels only in frames 0 and 3; frame_active shows the pattern 1,0,0,1,0,0.
- Fragment: href high for 5 beats with BEATS_PER_PIX=2 → 2 pixels, then frag_err pulses once and err_cnt=1. The next line starts at x=0 with y incremented.
- Coordinates/eol: 3 lines × 640 pixels → eol on x=639 only, y runs 0..2, and the last pixel of the frame has x=639, y=2.
- Reset mid-frame: assert sys_rst during line 1 of an ACTIVE frame → all outputs are 0 immediately and no pix_valid appears until PIC_WAIT new vs_rise events have passed.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types and helpers for the DVP capture front end.
package dvp_pkg;

    typedef enum logic [1:0] {
        WAIT,
        IDLE,
        ACTIVE,
        SKIP
    } frame_state_t;

    localparam int ERR_W = 8;

    // Slot that beat number `beat` occupies inside a pixel word.
    function automatic int unsigned slot_idx(int unsigned beat, logic lsb_first, int unsigned beats);
        return lsb_first ? beat : (beats - 1 - beat);
    endfunction

endpackage

// File: rtl/dvp_capture_if.sv
// Packed-pixel output bus from the capture front end to the frame-buffer writer.
interface dvp_capture_if #(
    parameter int DATA_W        = 8,
    parameter int BEATS_PER_PIX = 2,
    parameter int X_W           = 12,
    parameter int Y_W           = 12
);
    logic                            pix_valid;
    logic [DATA_W*BEATS_PER_PIX-1:0] pix_data;
    logic [X_W-1:0]                  pix_x;
    logic [Y_W-1:0]                  pix_y;
    logic                            sof;
    logic                            eol;

    modport master (output pix_valid, pix_data, pix_x, pix_y, sof, eol);
    modport slave  (input  pix_valid, pix_data, pix_x, pix_y, sof, eol);
endinterface

// File: rtl/dvp_pix_pack.sv
// Beat packer: assembles BEATS_PER_PIX beats into one pixel, flags fragments, registers outputs.
module dvp_pix_pack
    import dvp_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BEATS_PER_PIX = 2,
    parameter int X_W           = 12,
    parameter int Y_W           = 12
) (
    input  logic              ov5640_pclk,
    input  logic              sys_rst,
    input  logic              active,
    input  logic              vs_rise,
    input  logic              href,
    input  logic              href_q,
    input  logic              href_now,
    input  logic [DATA_W-1:0] data,
    input  logic              lsb_first,
    input  logic [X_W-1:0]    x_cur,
    input  logic [Y_W-1:0]    y_cur,
    input  logic              sof_pend,
    output logic              pix_fire,
    output logic              frag_err,
    output logic [ERR_W-1:0]  err_cnt,
    dvp_capture_if.master     pix
);
    localparam int B_W   = (BEATS_PER_PIX > 1) ? $clog2(BEATS_PER_PIX) : 1;
    localparam int PIX_W = DATA_W * BEATS_PER_PIX;

    logic [B_W-1:0]   b;
    logic [PIX_W-1:0] work;
    logic [PIX_W-1:0] merged;
    logic             take;
    logic             frag;

    // A frame boundary aborts any partial pixel silently.
    assign take     = active & href & ~vs_rise;
    assign pix_fire = take && (b == B_W'(BEATS_PER_PIX - 1));
    assign frag     = active & ~vs_rise & href_q & ~href & (b != '0);

    always_comb begin
        // NOTE: default first so every path assigns merged and no latch is inferred.
        merged = work;
        merged[slot_idx(32'(b), lsb_first, BEATS_PER_PIX) * DATA_W +: DATA_W] = data;
    end

    // NOTE: work is fully rewritten before it is ever emitted, so it carries no reset.
    always_ff @(posedge ov5640_pclk) begin
        if (take) work <= merged;
    end

    always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            b             <= '0;
            frag_err      <= 1'b0;
            err_cnt       <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_data  <= '0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.sof       <= 1'b0;
            pix.eol       <= 1'b0;
        end else begin
            b <= (take && !pix_fire) ? b + B_W'(1) : '0;

            frag_err <= frag;
            if (frag && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);

            pix.pix_valid <= pix_fire;
            pix.sof       <= pix_fire & sof_pend;
            pix.eol       <= pix_fire & ~href_now;
            if (pix_fire) begin
                pix.pix_data <= merged;
                pix.pix_x    <= x_cur;
                pix.pix_y    <= y_cur;
            end
        end
    end

endmodule

// File: rtl/dvp_capture.sv
// DVP capture top: input sampling, frame FSM with start-up discard and decimation, coordinates.
module dvp_capture
    import dvp_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BEATS_PER_PIX = 2,
    parameter int PIC_WAIT      = 10,
    parameter int X_W           = 12,
    parameter int Y_W           = 12
) (
    input  logic              ov5640_pclk,
    input  logic              sys_rst,
    input  logic              ov5640_href,
    input  logic              ov5640_vsync,
    input  logic [DATA_W-1:0] ov5640_data,
    input  logic              cap_en,
    input  logic              lsb_first,
    input  logic [3:0]        skip,
    dvp_capture_if.master     pix,
    output logic              frag_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              frame_active
);
    frame_state_t      state;
    logic              href_r, href_q, vsync_r, vsync_q;
    logic [DATA_W-1:0] data_r;
    logic [7:0]        wait_cnt;
    logic [3:0]        dec_cnt, dec_eff, skip_q;
    logic              cap_en_q, lsb_q, sof_pend;
    logic [X_W-1:0]    x_cnt, x_cur;
    logic [Y_W-1:0]    y_cnt;
    logic              line_pix, pix_fire;
    logic              vs_rise, href_rise, href_fall;

    assign vs_rise   = vsync_r & ~vsync_q;
    assign href_rise = href_r & ~href_q;
    assign href_fall = href_q & ~href_r;
    assign dec_eff   = (cap_en && !cap_en_q) ? 4'd0 : dec_cnt;
    assign x_cur     = href_rise ? '0 : x_cnt;

    always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (sys_rst) begin
            href_r  <= 1'b0;
            href_q  <= 1'b0;
            vsync_r <= 1'b0;
            vsync_q <= 1'b0;
            data_r  <= '0;
        end else begin
            href_r  <= ov5640_href;
            href_q  <= href_r;
            vsync_r <= ov5640_vsync;
            vsync_q <= vsync_r;
            data_r  <= ov5640_data;
        end
    end

    always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= WAIT;
            frame_active <= 1'b0;
            wait_cnt     <= '0;
            dec_cnt      <= '0;
            skip_q       <= '0;
            cap_en_q     <= 1'b0;
            lsb_q        <= 1'b0;
            sof_pend     <= 1'b0;
        end else if (vs_rise) begin
            cap_en_q <= cap_en;
            if (state == WAIT && wait_cnt != 8'(PIC_WAIT)) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else if (!cap_en) begin
                state        <= IDLE;
                frame_active <= 1'b0;
                sof_pend     <= 1'b0;
                dec_cnt      <= (dec_cnt >= skip_q) ? 4'd0 : dec_cnt + 4'd1;
            end else begin
                skip_q  <= skip;
                lsb_q   <= lsb_first;
                dec_cnt <= (dec_eff >= skip) ? 4'd0 : dec_eff + 4'd1;
                if (dec_eff == 4'd0) begin
                    state        <= ACTIVE;
                    frame_active <= 1'b1;
                    sof_pend     <= 1'b1;
                end else begin
                    state        <= SKIP;
                    frame_active <= 1'b0;
                    sof_pend     <= 1'b0;
                end
            end
        end else if (pix_fire) begin
            sof_pend <= 1'b0;
        end
    end

    // Lines only count toward pix_y once they actually produced a pixel.
    always_ff @(posedge ov5640_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            x_cnt    <= '0;
            y_cnt    <= '0;
            line_pix <= 1'b0;
        end else begin
            if (href_rise)                     x_cnt <= pix_fire ? X_W'(1) : '0;
            else if (pix_fire && x_cnt != '1) x_cnt <= x_cnt + X_W'(1);

            if (vs_rise) begin
                y_cnt    <= '0;
                line_pix <= 1'b0;
            end else if (href_fall) begin
                if (frame_active && line_pix) y_cnt <= y_cnt + Y_W'(1);
                line_pix <= 1'b0;
            end else if (pix_fire) begin
                line_pix <= 1'b1;
            end
        end
    end

    dvp_pix_pack #(
        .DATA_W       (DATA_W),
        .BEATS_PER_PIX(BEATS_PER_PIX),
        .X_W          (X_W),
        .Y_W          (Y_W)
    ) u_pack (
        .ov5640_pclk(ov5640_pclk),
        .sys_rst    (sys_rst),
        .active     (frame_active),
        .vs_rise    (vs_rise),
        .href       (href_r),
        .href_q     (href_q),
        .href_now   (ov5640_href),
        .data       (data_r),
        .lsb_first  (lsb_q),
        .x_cur      (x_cur),
        .y_cur      (y_cnt),
        .sof_pend   (sof_pend),
        .pix_fire   (pix_fire),
        .frag_err   (frag_err),
        .err_cnt    (err_cnt),
        .pix        (pix)
    );

endmodule

// File: tb/tb_dvp_capture.sv
// Directed scoreboard bench for dvp_capture (PIC_WAIT=3, 2 beats per pixel).
module tb_dvp_capture;
    localparam int DW = 8;
    localparam int BP = 2;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic          href, vsync;
    logic [DW-1:0] data;
    logic          cap_en, lsb_first;
    logic [3:0]    skip;
    logic          frag_err, frame_active;
    logic [7:0]    err_cnt;

    dvp_capture_if #(.DATA_W(DW), .BEATS_PER_PIX(BP), .X_W(12), .Y_W(12)) pif ();

    dvp_capture #(
        .DATA_W(DW), .BEATS_PER_PIX(BP), .PIC_WAIT(3), .X_W(12), .Y_W(12)
    ) dut (
        .ov5640_pclk (clk),
        .sys_rst     (sys_rst),
        .ov5640_href (href),
        .ov5640_vsync(vsync),
        .ov5640_data (data),
        .cap_en      (cap_en),
        .lsb_first   (lsb_first),
        .skip        (skip),
        .pix         (pif),
        .frag_err    (frag_err),
        .err_cnt     (err_cnt),
        .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*BP-1:0] data;
        int               x;
        int               y;
        bit               sof;
        bit               eol;
    } exp_t;

    exp_t       sb[$];
    exp_t       got;
    int         total = 0;
    int         bad   = 0;
    int         pix_pushed = 0;
    int         pix_seen   = 0;
    int         frag_seen  = 0;
    bit         sof_exp;
    logic [7:0] beat;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frag_err === 1'b1) frag_seen++;
        if (pif.pix_valid === 1'b1) begin
            pix_seen++;
            check("pix_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("pix_data", 32'(pif.pix_data), 32'(got.data));
                check("pix_x", 32'(pif.pix_x), got.x);
                check("pix_y", 32'(pif.pix_y), got.y);
                check("sof", 32'(pif.sof), 32'(got.sof));
                check("eol", 32'(pif.eol), 32'(got.eol));
            end
        end
    end

    task automatic vs_pulse();
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Drives one line of n beats; pushes expected pixels when the frame is captured.
    task automatic send_line(int n, bit cap, bit lsb, int y, bit tail);
        logic [DW*BP-1:0] acc = '0;
        int x = 0;
        int slot;
        for (int i = 0; i < n; i++) begin
            href = 1'b1;
            data = beat;
            slot = lsb ? (i % BP) : (BP - 1 - (i % BP));
            acc[slot*DW +: DW] = beat;
            if (cap && (i % BP) == BP - 1) begin
                sb.push_back('{data: acc, x: x, y: y, sof: sof_exp, eol: tail && (i == n - 1)});
                pix_pushed++;
                sof_exp = 1'b0;
                x++;
            end
            beat = beat + 8'h22;
            @(negedge clk);
        end
        if (tail) begin
            href = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_frame(int lines, int n, bit cap, bit lsb, bit exp_active, logic [7:0] b0);
        vs_pulse();
        check("frame_active", 32'(frame_active), 32'(exp_active));
        sof_exp = cap;
        beat    = b0;
        for (int l = 0; l < lines; l++) send_line(n, cap, lsb, l, 1'b1);
    endtask

    initial begin
        sys_rst = 1'b1; href = 1'b0; vsync = 1'b0; data = '0;
        cap_en = 1'b1; lsb_first = 1'b0; skip = 4'd0; beat = 8'h12;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pif.pix_valid), 0);
        check("rst_data", 32'(pif.pix_data), 0);
        check("rst_x", 32'(pif.pix_x), 0);
        check("rst_y", 32'(pif.pix_y), 0);
        check("rst_sof_eol", 32'({pif.sof, pif.eol}), 0);
        check("rst_frag", 32'(frag_err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_active", 32'(frame_active), 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        // Start-up discard: three frames dropped, the fourth captured.
        for (int f = 0; f < 4; f++) send_frame(2, 8, f == 3, 1'b0, f == 3, 8'h12);

        // Byte order latched at vs_rise; mid-frame toggle must not take effect.
        lsb_first = 1'b1;
        vs_pulse();
        check("active_lsb", 32'(frame_active), 1);
        sof_exp = 1'b1;
        beat    = 8'hAB;
        send_line(4, 1'b1, 1'b1, 0, 1'b1);
        lsb_first = 1'b0;
        send_line(4, 1'b1, 1'b1, 1, 1'b1);

        // Disabled frame, then decimation with skip=2.
        cap_en = 1'b0;
        send_frame(1, 4, 1'b0, 1'b0, 1'b0, 8'h01);
        cap_en = 1'b1;
        skip   = 4'd2;
        for (int f = 0; f < 6; f++) send_frame(1, 4, (f % 3) == 0, 1'b0, (f % 3) == 0, 8'h10);

        // Fragment: 5 beats give 2 pixels and one error; next line restarts x, bumps y.
        skip = 4'd0;
        vs_pulse();
        check("active_frag", 32'(frame_active), 1);
        sof_exp = 1'b1;
        beat    = 8'h40;
        send_line(5, 1'b1, 1'b0, 0, 1'b1);
        send_line(4, 1'b1, 1'b0, 1, 1'b1);
        check("frag_pulses", frag_seen, 1);
        check("err_cnt_1", 32'(err_cnt), 1);

        // Full-width lines: eol only at x=639, y runs 0..2.
        send_frame(3, 640 * BP, 1'b1, 1'b0, 1'b1, 8'h05);
        check("frag_none_new", frag_seen, 1);

        // Reset in the middle of line 0 of an active frame.
        vs_pulse();
        check("active_pre_rst", 32'(frame_active), 1);
        sof_exp = 1'b1;
        beat    = 8'h21;
        send_line(6, 1'b1, 1'b0, 0, 1'b0);
        data = beat;
        repeat (2) @(negedge clk);
        sys_rst = 1'b1;
        href    = 1'b0;
        #1;
        check("mid_rst_valid", 32'(pif.pix_valid), 0);
        check("mid_rst_data", 32'(pif.pix_data), 0);
        check("mid_rst_xy", 32'({pif.pix_x, pif.pix_y}), 0);
        check("mid_rst_err_cnt", 32'(err_cnt), 0);
        check("mid_rst_active", 32'(frame_active), 0);
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 4; f++) send_frame(1, 4, f == 3, 1'b0, f == 3, 8'h12);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("pix_count", pix_seen, pix_pushed);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
